// File: rtl/blake2_pkg.sv
// blake2_pkg: shared types and constants for the BLAKE2s sequencer.
//   ctrl_state_e   : sequencer states (IDLE, LOAD, PAD, WAIT, OUT)
//   BLAKE2S_BB     : block size in bytes
//   BLAKE2S_NN_MAX : largest digest length in bytes
//   PAD_BYTE       : fill byte for the tail of the final block
package blake2_pkg;

    localparam int         BLAKE2S_BB     = 64;
    localparam int         BLAKE2S_NN_MAX = 32;
    localparam logic [7:0] PAD_BYTE       = 8'h00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/blake2s_ctrl_wdog.sv
// blake2s_ctrl_wdog: compression-wait watchdog for blake2s_ctrl.
// Only instantiated when BLAKE2_CTRL_WDOG_EN is defined.
//   clk, nreset : clock, synchronous active-low reset
//   run         : sequencer is waiting on the core
//   finished    : core finished pulse
//   clr         : new command accepted, clears the sticky error
//   timeout     : one-cycle pulse, the wait ran too long
//   err         : sticky error flag
module blake2s_ctrl_wdog #(
    parameter int WDOG_W = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic run,
    input  logic finished,
    input  logic clr,
    output logic timeout,
    output logic err
);

    // The counter trips in the cycle its next value would be all-ones,
    // so the error shows after 2^WDOG_W-1 waiting cycles.
    localparam logic [WDOG_W-1:0] CNT_TRIP = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] cnt;

    assign timeout = run && !finished && (cnt == CNT_TRIP);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (run && !finished)
                cnt <= cnt + WDOG_W'(1);
            else
                cnt <= '0;

            if (clr)
                err <= 1'b0;
            else if (timeout)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/blake2s_ctrl.sv
// blake2s_ctrl: sequencer for the blake2s_hash256 core.
// Takes a hash command (message length, digest length) and a byte stream,
// chops it into BB-byte blocks, zero-pads the final block, feeds the core
// one byte per cycle and streams the digest back out.
// Optional feature macro: BLAKE2_CTRL_WDOG_EN (bounded wait on the core,
// sticky err_o); without it err_o is tied low.
// Ports:
//   clk, nreset                    : clock, synchronous active-low reset
//   cmd_v_i/cmd_ready_o            : command handshake
//   cmd_ll_i, cmd_nn_i             : message length (bytes), digest length
//   s_v_i/s_ready_o, s_data_i      : message byte stream
//   core_kk_o/nn_o/ll_o            : key len (0), latched nn, latched ll
//   core_block_first_o/last_o      : block position flags
//   core_data_v_o/idx_o/core_data_o: byte write into the core block buffer
//   core_finished_i, core_h_i      : compression done pulse, digest byte
//   h_v_o, h_o, h_last_o           : digest byte stream
//   err_o                          : watchdog error
module blake2s_ctrl
    import blake2_pkg::*;
#(
    parameter int BB     = BLAKE2S_BB,
    parameter int WDOG_W = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_v_i,
    output logic        cmd_ready_o,
    input  logic [63:0] cmd_ll_i,
    input  logic [5:0]  cmd_nn_i,
    input  logic        s_v_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    output logic [5:0]  core_kk_o,
    output logic [5:0]  core_nn_o,
    output logic [63:0] core_ll_o,
    output logic        core_block_first_o,
    output logic        core_block_last_o,
    output logic        core_data_v_o,
    output logic [5:0]  core_data_idx_o,
    output logic [7:0]  core_data_o,
    input  logic        core_finished_i,
    input  logic [7:0]  core_h_i,
    output logic        h_v_o,
    output logic [7:0]  h_o,
    output logic        h_last_o,
    output logic        err_o
);

    localparam logic [5:0]  IDX_LAST = 6'(BB - 1);
    localparam logic [63:0] BB_LEN   = 64'(BB);

    ctrl_state_e state, state_nxt;

    logic [63:0] rem;   // message bytes still to be accepted
    logic [5:0]  idx;   // next byte slot in the current block
    logic [5:0]  oc;    // digest bytes emitted so far
    logic        cmd_acc;
    logic        s_acc;
    logic        wdog_to;

    assign cmd_ready_o = (state == IDLE);
    assign s_ready_o   = (state == LOAD) && (rem != '0);
    assign cmd_acc     = cmd_v_i && cmd_ready_o;
    assign s_acc       = s_v_i && s_ready_o;
    assign core_kk_o   = 6'd0;

`ifdef BLAKE2_CTRL_WDOG_EN
    blake2s_ctrl_wdog #(
        .WDOG_W   (WDOG_W)
    ) u_wdog (
        .clk      (clk),
        .nreset   (nreset),
        .run      (state == WAIT),
        .finished (core_finished_i),
        .clr      (cmd_acc),
        .timeout  (wdog_to),
        .err      (err_o)
    );
`else
    assign wdog_to = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_acc)
                    state_nxt = (cmd_ll_i == '0) ? PAD : LOAD;
            end
            LOAD: begin
                // A full block wins over "message ran out": the last byte
                // landing in slot 63 needs no padding.
                if (s_acc) begin
                    if (idx == IDX_LAST)
                        state_nxt = WAIT;
                    else if (rem == 64'd1)
                        state_nxt = PAD;
                end
            end
            PAD: begin
                if (idx == IDX_LAST)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (core_finished_i)
                    state_nxt = core_block_last_o ? OUT : LOAD;
                else if (wdog_to)
                    state_nxt = IDLE;
            end
            OUT: begin
                if (oc == core_nn_o - 6'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. core_block_first_o/last_o are the block-position registers
    // themselves, so they only move at command accept and between blocks.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rem                <= '0;
            idx                <= '0;
            oc                 <= '0;
            core_nn_o          <= '0;
            core_ll_o          <= '0;
            core_block_first_o <= 1'b0;
            core_block_last_o  <= 1'b0;
            core_data_v_o      <= 1'b0;
            core_data_idx_o    <= '0;
            core_data_o        <= '0;
            h_v_o              <= 1'b0;
            h_o                <= '0;
            h_last_o           <= 1'b0;
        end else begin
            core_data_v_o <= 1'b0;
            h_v_o         <= 1'b0;
            h_last_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        core_ll_o          <= cmd_ll_i;
                        core_nn_o          <= cmd_nn_i;
                        rem                <= cmd_ll_i;
                        idx                <= '0;
                        core_block_first_o <= 1'b1;
                        core_block_last_o  <= (cmd_ll_i <= BB_LEN);
                    end
                end
                LOAD: begin
                    if (s_acc) begin
                        core_data_v_o   <= 1'b1;
                        core_data_idx_o <= idx;
                        core_data_o     <= s_data_i;
                        idx             <= idx + 6'd1;
                        rem             <= rem - 64'd1;
                    end
                end
                PAD: begin
                    core_data_v_o   <= 1'b1;
                    core_data_idx_o <= idx;
                    core_data_o     <= PAD_BYTE;
                    idx             <= idx + 6'd1;
                end
                WAIT: begin
                    if (core_finished_i) begin
                        if (!core_block_last_o) begin
                            core_block_first_o <= 1'b0;
                            core_block_last_o  <= (rem <= BB_LEN);
                            idx                <= '0;
                        end else begin
                            oc <= '0;
                        end
                    end
                end
                OUT: begin
                    h_v_o    <= 1'b1;
                    h_o      <= core_h_i;
                    h_last_o <= (oc == core_nn_o - 6'd1);
                    oc       <= oc + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2s_ctrl.sv
// tb_blake2s_ctrl: self-checking bench for blake2s_ctrl.
// A table of hash commands is run through the sequencer against a small
// behavioural core; expected block writes and digest bytes go into queues
// when stimulus is driven and are popped as the DUT produces them.
module tb_blake2s_ctrl;

    localparam int WDOG_W_TB = 8;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_v_i = 1'b0;
    logic        cmd_ready_o;
    logic [63:0] cmd_ll_i = '0;
    logic [5:0]  cmd_nn_i = '0;
    logic        s_v_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  s_data_i = '0;
    logic [5:0]  core_kk_o, core_nn_o;
    logic [63:0] core_ll_o;
    logic        core_block_first_o, core_block_last_o;
    logic        core_data_v_o;
    logic [5:0]  core_data_idx_o;
    logic [7:0]  core_data_o;
    logic        core_finished_i;
    logic [7:0]  core_h_i = '0;
    logic        h_v_o;
    logic [7:0]  h_o;
    logic        h_last_o;
    logic        err_o;
    logic        fin_pulse = 1'b0;
    logic        stray = 1'b0;

    assign core_finished_i = fin_pulse | stray;

    blake2s_ctrl #(.BB(64), .WDOG_W(WDOG_W_TB)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
        .cmd_ll_i(cmd_ll_i), .cmd_nn_i(cmd_nn_i),
        .s_v_i(s_v_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
        .core_block_first_o(core_block_first_o),
        .core_block_last_o(core_block_last_o),
        .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o),
        .core_data_o(core_data_o),
        .core_finished_i(core_finished_i), .core_h_i(core_h_i),
        .h_v_o(h_v_o), .h_o(h_o), .h_last_o(h_last_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] exp; bit msg; } wr_t;   // {first,last,idx,data}
    typedef struct { int ll; int nn; bit gap; bit abc; int blocks; } vec_t;

    wr_t         wq[$];
    logic [8:0]  hq[$];     // {last, byte}
    int          aq[$];     // cycle each message byte was accepted

    int n_tests = 0;
    int n_fail  = 0;
    int salt = 0;
    int cur_nn = 0;
    int nblk = 0;
    int fin_cyc = 0;
    int h_cnt = 0;
    int h_first_cyc = 0;
    int done_cnt = 0;
    int wr63_cyc = 0;
    bit core_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] dig_byte(input int k);
        return 8'(k * 29 + salt * 7 + 1);
    endfunction

    // Behavioural core: finishes a block three cycles after slot 63 is
    // written, then presents digest byte k in cycle k+1 after the pulse.
    initial begin
        int pend;
        int hk;
        bit pend_last;
        pend = 0; hk = -1; pend_last = 1'b0;
        forever begin
            @(negedge clk);
            fin_pulse = 1'b0;
            if (hk >= 0) begin
                core_h_i = dig_byte(hk);
                hk = (hk < 31) ? hk + 1 : -1;
            end
            if (!core_en) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    fin_pulse = 1'b1;
                    nblk++;
                    if (pend_last) begin
                        fin_cyc = cyc;
                        for (int k = 0; k < cur_nn; k++)
                            hq.push_back({k == cur_nn - 1, dig_byte(k)});
                        hk = 0;
                    end
                end
            end
            if (core_en && nreset && core_data_v_o && core_data_idx_o == 6'd63) begin
                pend = 3;
                pend_last = core_block_last_o;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        bit prev_hv;
        wr_t e;
        logic [8:0] he;
        int a;
        prev_hv = 1'b0;
        forever begin
            @(negedge clk);
            if (core_data_v_o) begin
                if (core_data_idx_o == 6'd63) wr63_cyc = cyc;
                if (wq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_unexpected: got idx %0d data %0h, required no write",
                             core_data_idx_o, core_data_o);
                end else begin
                    e = wq.pop_front();
                    check("wr{first,last,idx,data}",
                          {core_block_first_o, core_block_last_o, core_data_idx_o, core_data_o}, e.exp);
                    if (e.msg) begin
                        if (aq.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL wr_latency: got forwarded byte, required no unaccepted byte");
                        end else begin
                            a = aq.pop_front();
                            check("wr_latency", cyc - a, 1);
                        end
                    end
                end
            end
            if (h_v_o) begin
                if (!prev_hv) h_first_cyc = cyc;
                h_cnt++;
                if (hq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL h_unexpected: got %0h, required no digest byte", h_o);
                end else begin
                    he = hq.pop_front();
                    check("h{last,byte}", {h_last_o, h_o}, he);
                end
                if (h_last_o) done_cnt++;
            end
            prev_hv = h_v_o;
        end
    end

    task automatic check_reset_vals(input string nm);
        check({nm, ":cmd_ready"}, cmd_ready_o, 1);
        check({nm, ":s_ready"}, s_ready_o, 0);
        check({nm, ":core_ll"}, core_ll_o, 0);
        check({nm, ":core_nn_kk"}, {core_nn_o, core_kk_o}, 0);
        check({nm, ":core_blk"}, {core_block_first_o, core_block_last_o, core_data_v_o,
                                 core_data_idx_o, core_data_o}, 0);
        check({nm, ":h_err"}, {h_v_o, h_o, h_last_o, err_o}, 0);
    endtask

    task automatic send_cmd(input string nm, input int ll, input int nn);
        int t;
        t = 0;
        while (cmd_ready_o !== 1'b1 && t < 100) begin step(); t++; end
        check({nm, ":cmd_ready"}, cmd_ready_o, 1);
        cmd_v_i = 1'b1; cmd_ll_i = 64'(ll); cmd_nn_i = 6'(nn);
        step();
        cmd_v_i = 1'b0;
    endtask

    task automatic run_hash(input string nm, input vec_t v);
        logic [7:0] msg[$];
        int nb, i, t, extra, d0, nb0, hc0;
        bit tog;
        salt++;
        for (int k = 0; k < v.ll; k++)
            msg.push_back(v.abc ? 8'(8'h61 + k) : 8'(k * 13 + salt));
        nb = (v.ll == 0) ? 1 : (v.ll + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            for (int x = 0; x < 64; x++) begin
                int p;
                wr_t e;
                p = b * 64 + x;
                e.msg = (p < v.ll);
                e.exp = {b == 0, b == nb - 1, 6'(x), (p < v.ll) ? msg[p] : 8'h00};
                wq.push_back(e);
            end
        end
        cur_nn = v.nn; nb0 = nblk; hc0 = h_cnt; d0 = done_cnt;
        send_cmd(nm, v.ll, v.nn);

        i = 0; t = 0; tog = 1'b0;
        while (i < v.ll && t < 5000) begin
            if (v.gap && tog) s_v_i = 1'b0;
            else begin s_v_i = 1'b1; s_data_i = msg[i]; end
            if (v.gap && tog && i == 1) stray = 1'b1;   // stray pulse in LOAD
            if (s_v_i && s_ready_o) begin aq.push_back(cyc); i++; end
            tog = ~tog;
            step();
            stray = 1'b0;
            t++;
        end
        s_v_i = 1'b0;
        check({nm, ":bytes_sent"}, i, v.ll);

        extra = 0; t = 0;
        while (done_cnt == d0 && t < 3000) begin
            if (s_ready_o) extra++;
            step();
            t++;
        end
        check({nm, ":done"}, done_cnt != d0, 1);
        check({nm, ":s_ready_after_msg"}, extra, 0);
        check({nm, ":blocks"}, nblk - nb0, v.blocks);
        check({nm, ":digest_len"}, h_cnt - hc0, v.nn);
        check({nm, ":digest_latency"}, h_first_cyc - fin_cyc, 2);
        check({nm, ":leftover"}, wq.size() + hq.size() + aq.size(), 0);
        step();
        check({nm, ":cmd_ready_after_last"}, cmd_ready_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[8];
        int k, t, dt;
        tv[0] = '{ll:3,   nn:32, gap:0, abc:1, blocks:1};
        tv[1] = '{ll:0,   nn:32, gap:0, abc:0, blocks:1};
        tv[2] = '{ll:64,  nn:16, gap:0, abc:0, blocks:1};
        tv[3] = '{ll:65,  nn:20, gap:0, abc:0, blocks:2};
        tv[4] = '{ll:10,  nn:8,  gap:1, abc:0, blocks:1};
        tv[5] = '{ll:1,   nn:1,  gap:0, abc:0, blocks:1};
        tv[6] = '{ll:130, nn:32, gap:0, abc:0, blocks:3};
        tv[7] = '{ll:128, nn:5,  gap:1, abc:0, blocks:2};

        nreset = 1'b0;
        step(); step(); step();
        check_reset_vals("reset");
        nreset = 1'b1;
        step();

        for (int n = 0; n < 8; n++)
            run_hash($sformatf("vec%0d", n), tv[n]);

        // Reset while loading: 20 bytes in, idx register at 20.
        salt++;
        send_cmd("rst_mid", 100, 32);
        k = 0; t = 0;
        while (k < 20 && t < 200) begin
            s_v_i = 1'b1; s_data_i = 8'(8'h30 + k);
            if (s_ready_o) begin
                wq.push_back('{exp: {1'b1, 1'b0, 6'(k), 8'(8'h30 + k)}, msg: 1'b1});
                aq.push_back(cyc);
                k++;
            end
            step();
            t++;
        end
        s_v_i = 1'b0;
        step();                 // byte with idx 19 drains to the core
        nreset = 1'b0;
        step();
        check_reset_vals("rst_mid");
        check("rst_mid:drained", wq.size(), 0);
        wq.delete(); aq.delete(); hq.delete();
        nreset = 1'b1;
        step();
        run_hash("after_rst", tv[0]);

`ifdef BLAKE2_CTRL_WDOG_EN
        core_en = 1'b0;
        for (int x = 0; x < 64; x++)
            wq.push_back('{exp: {1'b1, 1'b1, 6'(x), 8'h00}, msg: 1'b0});
        send_cmd("wdog", 0, 32);
        t = 0;
        while (err_o !== 1'b1 && t < 1000) begin step(); t++; end
        dt = cyc - wr63_cyc;
        check("wdog:err", err_o, 1);
        check("wdog:wait_cycles", dt, (1 << WDOG_W_TB) - 1);
        check("wdog:idle", cmd_ready_o, 1);
        cmd_v_i = 1'b1; cmd_ll_i = 64'd0; cmd_nn_i = 6'd32;
        step();
        cmd_v_i = 1'b0;
        check("wdog:err_cleared", err_o, 0);
        nreset = 1'b0;
        step();
        wq.delete(); aq.delete(); hq.delete();
        nreset = 1'b1;
        core_en = 1'b1;
        step();
`else
        dt = 0;
        check("err_tied_low", err_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
